lfsr16_checker: RTL and testbench

- PRBS checker and receive-side counterpart of the team's 16-bit Galois LFSR generator: polynomial 16'hb400, right-shift, reset seed 16'hace1.
- Consumes PARALLEL_SAMPLES-wide beats of LFSR words, self-synchronises to the incoming sequence, then verifies every lane against a local free-running predictor.
- Reports lock status, a per-beat error flag, and saturating error and sample counters.
- Used on DAC/ADC loopback and internal datapaths for link integrity/BER measurement.

---
 rtl/lfsr16_checker.sv | 143 ++++++++++++++
 tb/tb_lfsr16_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr16_checker.sv
// PRBS checker for the 16-bit Galois LFSR (poly 0xb400, right shift).
// Self-synchronises to a multi-lane beat stream, then checks each lane against a free-running predictor.
module lfsr16_checker #(
  parameter int PARALLEL_SAMPLES = 4,
  parameter int LOCK_COUNT       = 8,
  parameter int UNLOCK_COUNT     = 4,
  parameter int COUNT_WIDTH      = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [PARALLEL_SAMPLES-1:0][15:0]    data_in,
  input  logic                                 data_valid,
  input  logic                                 clear_counts,
  output logic                                 locked,
  output logic                                 error_flag,
  output logic [COUNT_WIDTH-1:0]               error_count,
  output logic [COUNT_WIDTH-1:0]               sample_count
);

  localparam int P   = PARALLEL_SAMPLES;
  localparam int MW  = $clog2(LOCK_COUNT + 1);
  localparam int BW  = $clog2(UNLOCK_COUNT + 1);
  localparam int PCW = $clog2(P + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t                   state_reg;
  logic [P-1:0][15:0]       expected_reg;
  logic                     seeded_reg;
  logic [MW-1:0]            match_run_reg;
  logic [BW-1:0]            bad_run_reg;
  logic                     locked_reg;
  logic                     error_flag_reg;
  logic [COUNT_WIDTH-1:0]   error_count_reg;
  logic [COUNT_WIDTH-1:0]   sample_count_reg;

  logic [P-1:0][15:0]       seed_next;
  logic [P-1:0][15:0]       predict_next;
  logic [P-1:0]             mismatch;
  logic [PCW-1:0]           mismatch_count;
  logic                     beat_counts;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return ({16{s[0]}} & 16'hb400) ^ {1'b0, s[15:1]};
  endfunction

  function automatic logic [15:0] lfsr_step_p(input logic [15:0] s);
    logic [15:0] v;
    v = s;
    for (int k = 0; k < P; k++) v = lfsr_step(v);
    return v;
  endfunction

  // Clamp to all-ones rather than wrap.
  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] a,
                                                     input logic [COUNT_WIDTH:0]   b);
    logic [COUNT_WIDTH:0] sum;
    sum = {1'b0, a} + b;
    return sum[COUNT_WIDTH] ? '1 : sum[COUNT_WIDTH-1:0];
  endfunction

  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      assign mismatch[gi]     = data_in[gi] != expected_reg[gi];
      assign seed_next[gi]    = lfsr_step_p(data_in[gi]);
      assign predict_next[gi] = lfsr_step_p(expected_reg[gi]);
    end
  endgenerate

  always_comb begin
    mismatch_count = '0;
    for (int k = 0; k < P; k++) mismatch_count = mismatch_count + PCW'(mismatch[k]);
  end

  // The all-zero word is the LFSR lock-up state, so it must never contribute toward lock.
  assign beat_counts = seeded_reg && (mismatch == '0) && (data_in[0] != 16'h0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= SEARCH;
      expected_reg     <= '0;
      seeded_reg       <= 1'b0;
      match_run_reg    <= '0;
      bad_run_reg      <= '0;
      locked_reg       <= 1'b0;
      error_flag_reg   <= 1'b0;
      error_count_reg  <= '0;
      sample_count_reg <= '0;
    end else begin
      error_flag_reg <= 1'b0;
      if (data_valid) begin
        case (state_reg)
          SEARCH: begin
            expected_reg <= seed_next;
            seeded_reg   <= 1'b1;
            if (beat_counts) begin
              if (match_run_reg == MW'(LOCK_COUNT - 1)) begin
                state_reg     <= LOCKED;
                locked_reg    <= 1'b1;
                bad_run_reg   <= '0;
                match_run_reg <= '0;
              end else begin
                match_run_reg <= match_run_reg + 1'b1;
              end
            end else begin
              match_run_reg <= '0;
            end
          end
          LOCKED: begin
            expected_reg     <= predict_next;
            sample_count_reg <= sat_add(sample_count_reg, (COUNT_WIDTH+1)'(P));
            error_count_reg  <= sat_add(error_count_reg, (COUNT_WIDTH+1)'(mismatch_count));
            error_flag_reg   <= |mismatch;
            if (|mismatch) begin
              if (bad_run_reg == BW'(UNLOCK_COUNT - 1)) begin
                state_reg     <= SEARCH;
                locked_reg    <= 1'b0;
                seeded_reg    <= 1'b0;
                match_run_reg <= '0;
                bad_run_reg   <= '0;
              end else begin
                bad_run_reg <= bad_run_reg + 1'b1;
              end
            end else begin
              bad_run_reg <= '0;
            end
          end
          default: state_reg <= SEARCH;
        endcase
      end
      if (clear_counts) begin
        error_count_reg  <= '0;
        sample_count_reg <= '0;
      end
    end
  end

  assign locked       = locked_reg;
  assign error_flag   = error_flag_reg;
  assign error_count  = error_count_reg;
  assign sample_count = sample_count_reg;

endmodule

// File: tb/tb_lfsr16_checker.sv
// Directed + randomized bench for lfsr16_checker; a 32-bit and a 4-bit-counter instance share stimulus.
module tb_lfsr16_checker;

  localparam int P      = 4;
  localparam int LOCK   = 8;
  localparam int UNLOCK = 4;

  typedef logic [P-1:0][15:0] beat_t;

  logic        clk = 1'b0;
  logic        reset;
  beat_t       data_in;
  logic        data_valid;
  logic        clear_counts;
  logic        locked, error_flag;
  logic [31:0] error_count, sample_count;
  logic        locked_s, error_flag_s;
  logic [3:0]  error_count_s, sample_count_s;

  always #5 clk = ~clk;

  lfsr16_checker #(.PARALLEL_SAMPLES(P), .LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clear_counts(clear_counts),
    .locked(locked), .error_flag(error_flag), .error_count(error_count), .sample_count(sample_count));

  lfsr16_checker #(.PARALLEL_SAMPLES(P), .LOCK_COUNT(LOCK), .UNLOCK_COUNT(UNLOCK), .COUNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid), .clear_counts(clear_counts),
    .locked(locked_s), .error_flag(error_flag_s), .error_count(error_count_s), .sample_count(sample_count_s));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: unbounded counts, clamped per counter width when compared.
  bit          m_locked, m_seeded, m_flag;
  int          m_match, m_bad;
  logic [15:0] m_exp[P];
  longint      m_err, m_smp;
  logic [15:0] gen;

  function automatic logic [15:0] nxt(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hb400 : 16'h0000);
  endfunction

  function automatic logic [15:0] adv(input logic [15:0] s, input int n);
    logic [15:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = nxt(v);
    return v;
  endfunction

  function automatic beat_t gen_beat(input logic [15:0] s);
    beat_t b;
    for (int i = 0; i < P; i++) b[i] = adv(s, i);
    return b;
  endfunction

  function automatic longint clamp(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int bad_lanes;
    if (reset) begin
      m_locked = 0; m_seeded = 0; m_flag = 0; m_match = 0; m_bad = 0; m_err = 0; m_smp = 0;
      for (int i = 0; i < P; i++) m_exp[i] = 16'h0000;
      return;
    end
    m_flag = 0;
    if (data_valid) begin
      bad_lanes = 0;
      for (int i = 0; i < P; i++) if (data_in[i] != m_exp[i]) bad_lanes++;
      if (!m_locked) begin
        if (m_seeded && bad_lanes == 0 && data_in[0] != 16'h0000) m_match++;
        else m_match = 0;
        for (int i = 0; i < P; i++) m_exp[i] = adv(data_in[i], P);
        m_seeded = 1;
        if (m_match == LOCK) begin m_locked = 1; m_bad = 0; m_match = 0; end
      end else begin
        for (int i = 0; i < P; i++) m_exp[i] = adv(m_exp[i], P);
        m_smp += P;
        m_err += bad_lanes;
        m_flag = (bad_lanes > 0);
        m_bad  = (bad_lanes > 0) ? m_bad + 1 : 0;
        if (m_bad == UNLOCK) begin m_locked = 0; m_seeded = 0; m_match = 0; m_bad = 0; end
      end
    end
    if (clear_counts) begin m_err = 0; m_smp = 0; end
  endtask

  task automatic send(input bit valid, input beat_t d, input bit clr);
    data_valid   = valid;
    data_in      = d;
    clear_counts = clr;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    $display("cyc %0d rst=%0b v=%0b clr=%0b lane0=%h locked=%0b flag=%0b err=%0d smp=%0d smp4=%0d",
             cyc, reset, valid, clr, d[0], locked, error_flag, error_count, sample_count, sample_count_s);
    check($sformatf("locked@%0d", cyc),       64'(locked),         64'(m_locked));
    check($sformatf("flag@%0d", cyc),         64'(error_flag),     64'(m_flag));
    check($sformatf("err@%0d", cyc),          64'(error_count),    64'(clamp(m_err, 64'hFFFFFFFF)));
    check($sformatf("smp@%0d", cyc),          64'(sample_count),   64'(clamp(m_smp, 64'hFFFFFFFF)));
    check($sformatf("locked_w4@%0d", cyc),    64'(locked_s),       64'(m_locked));
    check($sformatf("flag_w4@%0d", cyc),      64'(error_flag_s),   64'(m_flag));
    check($sformatf("err_w4@%0d", cyc),       64'(error_count_s),  64'(clamp(m_err, 15)));
    check($sformatf("smp_w4@%0d", cyc),       64'(sample_count_s), 64'(clamp(m_smp, 15)));
  endtask

  task automatic send_gen(input bit valid, input int flip_lane, input int flip_bit, input bit clr);
    beat_t d;
    if (valid) begin
      d = gen_beat(gen);
      if (flip_lane >= 0) d[flip_lane][flip_bit] = ~d[flip_lane][flip_bit];
      gen = adv(gen, P);
      send(1'b1, d, clr);
    end else begin
      for (int i = 0; i < P; i++) d[i] = 16'($urandom);
      send(1'b0, d, clr);
    end
  endtask

  initial begin
    int     locked_at, beats;
    bit     flag_seen, lock_seen;
    longint err_before;

    reset = 1'b1; data_valid = 1'b0; clear_counts = 1'b0; data_in = '0;
    send(1'b0, '0, 1'b0);
    send(1'b1, gen_beat(16'hace1), 1'b1);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_err",    64'(error_count), 64'd0);
    reset = 1'b0;

    // Generator stream from the reset seed: lock after 1 seed beat + LOCK matches.
    gen = 16'hace1;
    locked_at = -1;
    for (int b = 1; b <= 20 && locked_at < 0; b++) begin
      send_gen(1'b1, -1, 0, 1'b0);
      if (locked) locked_at = b;
    end
    check("lock_latency", 64'(locked_at), 64'(LOCK + 1));

    flag_seen = 0;
    for (int k = 1; k <= 100; k++) begin
      send_gen(1'b1, -1, 0, 1'b0);
      if (error_flag) flag_seen = 1;
      if (k == 1) check("sat_first_beat", 64'(sample_count_s), 64'd4);
      if (k == 5) check("sat_clamp", 64'(sample_count_s), 64'd15);
    end
    check("clean_err", 64'(error_count), 64'd0);
    check("clean_smp", 64'(sample_count), 64'd400);
    check("clean_flag_seen", 64'(flag_seen), 64'd0);

    // Single bit error on lane 2.
    send_gen(1'b1, 2, 3, 1'b0);
    check("flip_flag", 64'(error_flag), 64'd1);
    check("flip_err", 64'(error_count), 64'd1);
    check("flip_locked", 64'(locked), 64'd1);
    send_gen(1'b1, -1, 0, 1'b0);
    check("flip_flag_clear", 64'(error_flag), 64'd0);
    check("flip_err_hold", 64'(error_count), 64'd1);

    // Switch to an unrelated seed: unlock after UNLOCK bad beats, then resync.
    gen = 16'($urandom_range(1, 65535));
    err_before = longint'(error_count);
    beats = 0;
    while (locked && beats < 10) begin
      send_gen(1'b1, -1, 0, 1'b0);
      beats++;
    end
    check("unlock_beats", 64'(beats), 64'(UNLOCK));
    check("unlock_err_bound", 64'(longint'(error_count) - err_before <= 16), 64'd1);
    beats = 0;
    while (!locked && beats < 20) begin
      send_gen(1'b1, -1, 0, 1'b0);
      beats++;
    end
    check("relock_beats", 64'(beats), 64'(LOCK + 1));

    // Alternate invalid cycles, then clear on an error beat, then reset while locked.
    for (int k = 0; k < 8; k++) begin
      send_gen(1'b0, -1, 0, 1'b0);
      send_gen(1'b1, -1, 0, 1'b0);
    end
    send_gen(1'b1, 0, 5, 1'b1);
    check("clear_err", 64'(error_count), 64'd0);
    check("clear_flag", 64'(error_flag), 64'd1);
    check("clear_locked", 64'(locked), 64'd1);
    reset = 1'b1;
    send_gen(1'b1, -1, 0, 1'b0);
    check("midreset_locked", 64'(locked), 64'd0);
    check("midreset_smp", 64'(sample_count), 64'd0);
    reset = 1'b0;

    // All-zero stream must never lock.
    lock_seen = 0;
    for (int k = 0; k < 20; k++) begin
      send(1'b1, '0, 1'b0);
      if (locked) lock_seen = 1;
    end
    check("zero_lock_seen", 64'(lock_seen), 64'd0);
    check("zero_smp", 64'(sample_count), 64'd0);

    // Random phase: random valid gaps, sparse bit errors, occasional clears.
    gen = 16'($urandom_range(1, 65535));
    for (int k = 0; k < 300; k++) begin
      send_gen($urandom_range(0, 3) != 0,
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, P - 1)) : -1,
               int'($urandom_range(0, 15)),
               $urandom_range(0, 40) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
